// File: rtl/conv2d_stream_engine.sv
// Serial 2-D valid-mode convolution: streams in a KS x KS kernel and an IMG x IMG
// feature map, computes one MAC per cycle, requantises, and streams results out.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_F | accepting kernel weights
// LOAD_I | accepting image pixels
// MAC    | accumulating one output, one product per cycle
// EMIT   | presenting a result until the sink accepts it
module conv2d_stream_engine #(
    parameter int DW     = 8,
    parameter int IMG    = 4,
    parameter int KS     = 3,
    parameter int ACCW   = 24,
    parameter int SHIFT  = 0,
    parameter int SIGNED = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          relu_en,
    input  logic          filt_valid,
    input  logic [DW-1:0] filt_data,
    output logic          filt_ready,
    input  logic          ifmap_valid,
    input  logic [DW-1:0] ifmap_data,
    output logic          ifmap_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam int OUT  = IMG - KS + 1;
    localparam int NK   = KS * KS;
    localparam int NPIX = IMG * IMG;
    localparam int IDXW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int KW   = (NK > 1) ? $clog2(NK) : 1;
    localparam int CW   = (IMG > 1) ? $clog2(IMG) : 1;

    localparam logic signed [ACCW-1:0] SMAX = ACCW'((1 << (DW - 1)) - 1);
    localparam logic signed [ACCW-1:0] SMIN = ~SMAX;
    localparam logic [ACCW-1:0]        UMAX = {{(ACCW - DW){1'b0}}, {DW{1'b1}}};

    if (KS > IMG) begin : g_ks_check
        $error("conv2d_stream_engine: KS must not exceed IMG");
    end
    if (ACCW < 2 * DW + $clog2(NK)) begin : g_accw_check
        $error("conv2d_stream_engine: ACCW too narrow for the kernel sum");
    end

    typedef enum logic [2:0] {IDLE, LOAD_F, LOAD_I, MAC, EMIT} state_t;

    state_t                  state_q, state_d;
    logic [IDXW-1:0]         ld_idx_q, ld_idx_d;
    logic [CW-1:0]           r_q, r_d, c_q, c_d;
    logic [CW-1:0]           kr_q, kr_d, kc_q, kc_d;
    logic [KW-1:0]           k_q, k_d;
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic                    relu_q, relu_d;
    logic                    filt_ready_q, filt_ready_d;
    logic                    ifmap_ready_q, ifmap_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [DW-1:0]           out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [DW-1:0]           w_mem   [NK];
    logic [DW-1:0]           pix_mem [NPIX];

    logic [CW-1:0]           row_sel, col_sel;
    logic [IDXW-1:0]         pix_addr;
    logic [DW-1:0]           pix_sel, w_sel;
    logic signed [ACCW-1:0]  pix_ext, w_ext, prod, acc_next;

    // Shift first, then optional ReLU, then clamp into the output range.
    function automatic logic [DW-1:0] requant(input logic signed [ACCW-1:0] a,
                                              input logic relu);
        logic signed [ACCW-1:0] qs;
        logic [ACCW-1:0]        qu;
        logic [DW-1:0]          res;
        qs = a >>> SHIFT;
        qu = $unsigned(a) >> SHIFT;
        if (SIGNED != 0) begin
            if (relu && qs[ACCW-1]) qs = '0;
            if (qs > SMAX)      res = SMAX[DW-1:0];
            else if (qs < SMIN) res = SMIN[DW-1:0];
            else                res = qs[DW-1:0];
        end else begin
            res = (qu > UMAX) ? {DW{1'b1}} : qu[DW-1:0];
        end
        return res;
    endfunction

    always_comb begin
        row_sel  = r_q + kr_q;
        col_sel  = c_q + kc_q;
        pix_addr = IDXW'(row_sel) * IDXW'(IMG) + IDXW'(col_sel);
        pix_sel  = pix_mem[pix_addr];
        w_sel    = w_mem[k_q];
        if (SIGNED != 0) begin
            pix_ext = {{(ACCW - DW){pix_sel[DW-1]}}, pix_sel};
            w_ext   = {{(ACCW - DW){w_sel[DW-1]}}, w_sel};
        end else begin
            pix_ext = {{(ACCW - DW){1'b0}}, pix_sel};
            w_ext   = {{(ACCW - DW){1'b0}}, w_sel};
        end
        prod     = pix_ext * w_ext;
        acc_next = (k_q == '0) ? prod : acc_q + prod;
    end

    always_comb begin
        state_d       = state_q;
        ld_idx_d      = ld_idx_q;
        r_d           = r_q;
        c_d           = c_q;
        kr_d          = kr_q;
        kc_d          = kc_q;
        k_d           = k_q;
        acc_d         = acc_q;
        relu_d        = relu_q;
        filt_ready_d  = filt_ready_q;
        ifmap_ready_d = ifmap_ready_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        busy_d        = busy_q;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = LOAD_F;
                    relu_d       = relu_en;
                    filt_ready_d = 1'b1;
                    busy_d       = 1'b1;
                    ld_idx_d     = '0;
                    r_d          = '0;
                    c_d          = '0;
                    kr_d         = '0;
                    kc_d         = '0;
                    k_d          = '0;
                end
            end
            LOAD_F: begin
                if (filt_valid && filt_ready_q) begin
                    if (ld_idx_q == IDXW'(NK - 1)) begin
                        state_d       = LOAD_I;
                        ld_idx_d      = '0;
                        filt_ready_d  = 1'b0;
                        ifmap_ready_d = 1'b1;
                    end else begin
                        ld_idx_d = ld_idx_q + IDXW'(1);
                    end
                end
            end
            LOAD_I: begin
                if (ifmap_valid && ifmap_ready_q) begin
                    if (ld_idx_q == IDXW'(NPIX - 1)) begin
                        state_d       = MAC;
                        ld_idx_d      = '0;
                        ifmap_ready_d = 1'b0;
                        r_d           = '0;
                        c_d           = '0;
                        kr_d          = '0;
                        kc_d          = '0;
                        k_d           = '0;
                    end else begin
                        ld_idx_d = ld_idx_q + IDXW'(1);
                    end
                end
            end
            MAC: begin
                acc_d = acc_next;
                if (k_q == KW'(NK - 1)) begin
                    state_d     = EMIT;
                    out_valid_d = 1'b1;
                    out_data_d  = requant(acc_next, relu_q);
                    out_last_d  = (r_q == CW'(OUT - 1)) && (c_q == CW'(OUT - 1));
                    k_d         = '0;
                    kr_d        = '0;
                    kc_d        = '0;
                end else begin
                    k_d = k_q + KW'(1);
                    if (kc_q == CW'(KS - 1)) begin
                        kc_d = '0;
                        kr_d = kr_q + CW'(1);
                    end else begin
                        kc_d = kc_q + CW'(1);
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        r_d     = '0;
                        c_d     = '0;
                    end else begin
                        state_d = MAC;
                        if (c_q == CW'(OUT - 1)) begin
                            c_d = '0;
                            r_d = r_q + CW'(1);
                        end else begin
                            c_d = c_q + CW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            ld_idx_q      <= '0;
            r_q           <= '0;
            c_q           <= '0;
            kr_q          <= '0;
            kc_q          <= '0;
            k_q           <= '0;
            acc_q         <= '0;
            relu_q        <= 1'b0;
            filt_ready_q  <= 1'b0;
            ifmap_ready_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ld_idx_q      <= ld_idx_d;
            r_q           <= r_d;
            c_q           <= c_d;
            kr_q          <= kr_d;
            kc_q          <= kc_d;
            k_q           <= k_d;
            acc_q         <= acc_d;
            relu_q        <= relu_d;
            filt_ready_q  <= filt_ready_d;
            ifmap_ready_q <= ifmap_ready_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Buffers keep their contents across reset; only the control path is cleared.
    always_ff @(posedge clk) begin
        if (state_q == LOAD_F && filt_valid && filt_ready_q)
            w_mem[KW'(ld_idx_q)] <= filt_data;
        if (state_q == LOAD_I && ifmap_valid && ifmap_ready_q)
            pix_mem[ld_idx_q] <= ifmap_data;
    end

    assign filt_ready  = filt_ready_q;
    assign ifmap_ready = ifmap_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Directed bench for conv2d_stream_engine: three instances (default, SHIFT=4,
// SIGNED=1) share one set of stimulus and run in lockstep.
module tb_conv2d_stream_engine;

    logic       clk, rst, start, relu_en, filt_valid, ifmap_valid, out_ready;
    logic [7:0] filt_data, ifmap_data;

    logic       filt_ready_a, ifmap_ready_a, out_valid_a, out_last_a, busy_a, done_a;
    logic       filt_ready_b, ifmap_ready_b, out_valid_b, out_last_b, busy_b, done_b;
    logic       filt_ready_c, ifmap_ready_c, out_valid_c, out_last_c, busy_c, done_c;
    logic [7:0] out_data_a, out_data_b, out_data_c;

    logic [7:0] kern_v [9];
    logic [7:0] img_v  [16];
    logic [7:0] res_a  [4];
    logic [7:0] res_b  [4];
    logic [7:0] res_c  [4];
    logic       last_a [4];
    int         n_out;
    int         npass  = 0;
    int         ntotal = 0;

    conv2d_stream_engine u_dut (
        .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
        .filt_valid(filt_valid), .filt_data(filt_data), .filt_ready(filt_ready_a),
        .ifmap_valid(ifmap_valid), .ifmap_data(ifmap_data), .ifmap_ready(ifmap_ready_a),
        .out_valid(out_valid_a), .out_data(out_data_a), .out_ready(out_ready),
        .out_last(out_last_a), .busy(busy_a), .done(done_a));

    conv2d_stream_engine #(.SHIFT(4)) u_sh4 (
        .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
        .filt_valid(filt_valid), .filt_data(filt_data), .filt_ready(filt_ready_b),
        .ifmap_valid(ifmap_valid), .ifmap_data(ifmap_data), .ifmap_ready(ifmap_ready_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready),
        .out_last(out_last_b), .busy(busy_b), .done(done_b));

    conv2d_stream_engine #(.SIGNED(1)) u_sgn (
        .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
        .filt_valid(filt_valid), .filt_data(filt_data), .filt_ready(filt_ready_c),
        .ifmap_valid(ifmap_valid), .ifmap_data(ifmap_data), .ifmap_ready(ifmap_ready_c),
        .out_valid(out_valid_c), .out_data(out_data_c), .out_ready(out_ready),
        .out_last(out_last_c), .busy(busy_c), .done(done_c));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_filt_ready_a"}, filt_ready_a, 0);
        check({tag, "_ifmap_ready_a"}, ifmap_ready_a, 0);
        check({tag, "_out_valid_a"}, out_valid_a, 0);
        check({tag, "_out_data_a"}, out_data_a, 0);
        check({tag, "_out_last_a"}, out_last_a, 0);
        check({tag, "_busy_a"}, busy_a, 0);
        check({tag, "_done_a"}, done_a, 0);
        check({tag, "_outs_b"}, {filt_ready_b, ifmap_ready_b, out_valid_b, out_data_b,
                                 out_last_b, busy_b, done_b}, 0);
        check({tag, "_outs_c"}, {filt_ready_c, ifmap_ready_c, out_valid_c, out_data_c,
                                 out_last_c, busy_c, done_c}, 0);
    endtask

    task automatic do_start(input bit relu);
        @(negedge clk);
        start   = 1'b1;
        relu_en = relu;
        @(negedge clk);
        start   = 1'b0;
        relu_en = 1'b0;
    endtask

    // Gappy mode toggles both valids and offers pixels while the kernel is still loading.
    task automatic load_streams(input bit gappy);
        int fi = 0, ii = 0, cyc = 0;
        bit f_hs, i_hs;
        while ((fi < 9 || ii < 16) && cyc < 200) begin
            filt_valid  = (fi < 9) && (!gappy || (cyc % 2 == 0));
            filt_data   = 8'h00;
            if (fi < 9) filt_data = kern_v[fi];
            ifmap_valid = (ii < 16) && (gappy ? (cyc % 2 == 1) : (fi >= 9));
            ifmap_data  = 8'h00;
            if (ii < 16) ifmap_data = img_v[ii];
            if (gappy && fi < 9) check("ifmap_ready_in_load_f", ifmap_ready_a, 0);
            f_hs = filt_valid && filt_ready_a;
            i_hs = ifmap_valid && ifmap_ready_a;
            @(posedge clk);
            if (f_hs) fi++;
            if (i_hs) ii++;
            @(negedge clk);
            cyc++;
        end
        filt_valid  = 1'b0;
        ifmap_valid = 1'b0;
        if (cyc >= 200) check("load_timeout", 0, 1);
    endtask

    task automatic collect(input int stall, input bit poke_start);
        int cyc = 0, held = 0;
        bit seen_done = 0, poked = 0;
        logic [7:0] first = 8'h00;
        n_out = 0;
        for (int i = 0; i < 4; i++) begin
            res_a[i] = 'x; res_b[i] = 'x; res_c[i] = 'x; last_a[i] = 'x;
        end
        out_ready = (stall == 0);
        while (!seen_done && cyc < 400) begin
            start = 1'b0;
            if (poke_start && n_out == 1 && !poked) begin
                start = 1'b1;
                poked = 1;
            end
            if (done_a) begin
                seen_done = 1;
                check("busy_low_with_done", busy_a, 0);
                check("done_sh4", done_b, 1);
                check("done_sgn", done_c, 1);
            end else if (out_valid_a) begin
                if (held < stall) begin
                    out_ready = 1'b0;
                    if (held == 0) first = out_data_a;
                    else check("stall_hold", out_data_a, first);
                    held++;
                end else begin
                    out_ready = 1'b1;
                    if (n_out < 4) begin
                        res_a[n_out]  = out_data_a;
                        res_b[n_out]  = out_data_b;
                        res_c[n_out]  = out_data_c;
                        last_a[n_out] = out_last_a;
                    end
                    n_out++;
                    held = 0;
                end
            end else begin
                out_ready = (stall == 0);
            end
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        if (!seen_done) check("done_timeout", 0, 1);
        check("out_count", n_out, 4);
        check("done_one_cycle", done_a, 0);
        check("busy_after_job", busy_a, 0);
    endtask

    task automatic run_job(input bit gappy, input int stall, input bit relu, input bit poke);
        do_start(relu);
        load_streams(gappy);
        collect(stall, poke);
    endtask

    task automatic check_res(input string tag, input int which,
                             input int e0, input int e1, input int e2, input int e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            if (which == 0)      check($sformatf("%s_a%0d", tag, i), res_a[i], e[i]);
            else if (which == 1) check($sformatf("%s_b%0d", tag, i), res_b[i], e[i]);
            else                 check($sformatf("%s_c%0d", tag, i), res_c[i], e[i]);
        end
    endtask

    task automatic set_case1();
        for (int i = 0; i < 9; i++)  kern_v[i] = 8'd1;
        for (int i = 0; i < 16; i++) img_v[i]  = 8'(i + 1);
    endtask

    initial begin
        int cyc;
        clk = 0; rst = 0; start = 0; relu_en = 0; out_ready = 0;
        filt_valid = 0; ifmap_valid = 0; filt_data = 0; ifmap_data = 0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1;

        // 1: default instance, kernel of ones over 1..16
        set_case1();
        run_job(0, 0, 0, 0);
        check_res("t1", 0, 54, 63, 90, 99);
        for (int i = 0; i < 4; i++) check($sformatf("t1_last%0d", i), last_a[i], (i == 3));
        check_res("t1_sh4", 1, 3, 3, 5, 6);

        // 2: saturation at SHIFT=0, in range at SHIFT=4
        for (int i = 0; i < 16; i++) img_v[i] = 8'd255;
        run_job(0, 0, 0, 0);
        check_res("t2", 0, 255, 255, 255, 255);
        check_res("t2_sh4", 1, 143, 143, 143, 143);

        // 3: sink back-pressure
        set_case1();
        run_job(0, 5, 0, 0);
        check_res("t3", 0, 54, 63, 90, 99);

        // 4: bubbly sources, pixels offered early
        run_job(1, 0, 0, 0);
        check_res("t4", 0, 54, 63, 90, 99);

        // 5: signed centre tap of -1, then with ReLU
        for (int i = 0; i < 9; i++) kern_v[i] = (i == 4) ? 8'hFF : 8'h00;
        run_job(0, 0, 0, 0);
        check_res("t5", 2, 250, 249, 246, 245);
        run_job(0, 0, 1, 0);
        check_res("t5_relu", 2, 0, 0, 0, 0);

        // 6: asynchronous reset while computing the second output
        set_case1();
        do_start(0);
        load_streams(0);
        out_ready = 1'b1;
        cyc = 0;
        while (!out_valid_a && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_first_out", out_data_a, 54);
        repeat (3) @(negedge clk);
        check("t6_busy_mid_mac", busy_a, 1);
        #2 rst = 0;
        #1 check_idle_outputs("t6_async_rst");
        @(negedge clk);
        rst = 1;
        run_job(0, 0, 0, 1);
        check_res("t6_rerun", 0, 54, 63, 90, 99);
        repeat (5) @(negedge clk);
        check("t6_no_extra_job", busy_a, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
